crc16_serial_tx: RTL and testbench
==================================

// Module: crc16_serial_tx
// PURPOSE
//  Transmit end of the serial CRC link. Loads a DATA_W-bit word on a start pulse.
//  Shifts the word out MSB-first, one bit per clock, while computing CRC-16 over it.
//  Then appends the 16-bit CRC, MSB-first, so the frame is DATA_W+16 bits (48 at default).
//  Drives the serial data/start pair of the lpset6 CRC receiver and of the lab serial links.
// PARAMETERS
//  DATA_W   32       payload bits per frame (8..64)
//  POLY     16'h8005 CRC generator polynomial, x^16 term implicit
//  INIT     16'h0000 CRC register value at frame start
// PORTS
//  clock      in   1       system clock, all flops on posedge
//  reset_n    in   1       asynchronous, active-low reset
//  start      in   1       1-cycle request; din captured on this edge when idle
//  din        in   DATA_W  payload word
//  bit_en     in   1       bit strobe; frame advances only on cycles with bit_en=1 (tie 1 for full rate)
//  sout       out  1       serial data, registered
//  sof        out  1       high with the first payload bit (receiver start)
//  sout_vld   out  1       high while sout carries a frame bit
//  busy       out  1       high from the start edge until done
//  done       out  1       1-cycle pulse after the last CRC bit is retired
//  crc        out  16      CRC of the last frame, valid from done until the next start
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE; sout, sof, sout_vld, busy and done=0; crc=16'h0.
//  States: IDLE -> DATA -> CRC -> FIN -> IDLE.
//   IDLE: on start=1, load the shift register with din and the crc register with INIT.
//         Clear bit count. Set busy=1 and go to DATA.
//   DATA: each bit_en cycle, present din bit DATA_W-1-k on sout (sout_vld=1) for k=0..DATA_W-1.
//         sof=1 only for k=0.
//         Same edge: fb = bit ^ crc[15]; crc <= {crc[14:0],1'b0} ^ (fb ? POLY : 16'h0).
//         After bit DATA_W-1, go to CRC.
//   CRC:  each bit_en cycle, send crc[15] and shift crc left with 0 fill.
//         Keep a saved copy of the final CRC for the crc output.
//         After 16 bits, go to FIN.
//   FIN:  done=1 for exactly one clock, busy=0, then go to IDLE.
//  Output timing:
//   - First bit: sout/sout_vld/sof are registered; they appear in the cycle after the first bit_en edge in DATA.
//   - Last bit: sout_vld drops in the cycle after the last CRC bit; FIN asserts done that same cycle.
//   - Latency: start edge to done is DATA_W+16+2 clocks at bit_en=1.
//  bit_en=0: hold sout, hold counters, deassert sout_vld and sof. Receiver sees a stall.
//  start while busy: ignored, no re-load; din is don't-care after the start edge.
//  start in the FIN cycle: ignored; accepted again from IDLE.
//  Reset mid-frame: abort immediately to IDLE, all outputs to reset values, no done.
//  Counter width $clog2(DATA_W)+1; the bit count does not wrap inside a frame.
//  The crc output updates only at the FIN edge.
// STRUCTURE
//  Shared header crc_defs.vh holds:
//   - CRC16_POLY, CRC16_INIT defaults
//   - state encodings S_IDLE=2'd0, S_DATA=2'd1, S_CRC=2'd2, S_FIN=2'd3
//  One sub-module, crc16_step (combinational): (crc_in[15:0], bit, POLY) -> crc_out[15:0].
//  The receiver reuses crc16_step so both ends share one LFSR definition.
// TESTING
//  1 din=32'h0000_0001, start pulse, bit_en=1
//    -> 48 sout bits: 31 zeros, a one, then 16'h8005 MSB-first; crc=16'h8005; done 50 clocks after start.
//  2 din=32'h0000_0002 -> crc=16'h800F, CRC bits 1000_0000_0000_1111 follow the payload.
//  3 din=32'h0301_0203 -> sout stream matches the bench's software LFSR model bit-for-bit.
//    A loopback into the lpset6 receiver shows r equal to crc and receiver done.
//  4 bit_en toggling 1,0,1,0 during din=32'h0000_0001
//    -> same 48-bit sequence as test 1, sout_vld only on enabled cycles, done about 96 clocks after start.
//  5 second start pulse at bit 10 of a frame -> ignored; frame and crc identical to the single-start case.
//  6 reset_n low at bit 20 -> outputs 0 asynchronously, no done.
//    A new start after release gives a clean frame, crc=16'h8005 for din=32'h1.

Source files
------------

// File: rtl/crc16_serial_tx_pkg.sv
// Shared definitions for the CRC-16 serial transmit slice.
// Contents:
//   CRC16_POLY / CRC16_INIT : default generator polynomial (x^16 implicit) and
//                             the value the CRC register starts each frame at
//   state_t                 : frame sequencer states, also exported on the
//                             top-level debug port
package crc16_serial_tx_pkg;

    localparam logic [15:0] CRC16_POLY = 16'h8005;
    localparam logic [15:0] CRC16_INIT = 16'h0000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_CRC  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

endpackage

// File: rtl/crc16_serial_tx_step.sv
// One bit of the CRC-16 LFSR, purely combinational.  The receiver uses the
// same block, so both ends of the link share one LFSR definition.
// Ports:
//   crc_in   in  16  current CRC register value
//   data_bit in  1   message bit entering the LFSR
//   crc_out  out 16  CRC register value after absorbing data_bit
module crc16_serial_tx_step
    import crc16_serial_tx_pkg::*;
#(
    parameter logic [15:0] POLY = CRC16_POLY
) (
    input  logic [15:0] crc_in,
    input  logic        data_bit,
    output logic [15:0] crc_out
);

    logic fb;

    // Feedback is the message bit XOR the bit falling off the top; when set,
    // the polynomial is folded into the shifted register.
    assign fb      = data_bit ^ crc_in[15];
    assign crc_out = {crc_in[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);

endmodule

// File: rtl/crc16_serial_tx.sv
// Transmit end of the serial CRC link.  A DATA_W-bit word is captured on a
// start pulse, shifted out MSB-first one bit per enabled clock while its
// CRC-16 is accumulated, and the 16-bit CRC is then appended MSB-first.
// Ports:
//   clock      in   1       system clock, all flops on posedge
//   reset_n    in   1       asynchronous active-low reset
//   start      in   1       1-cycle request; din captured on this edge when idle
//   din        in   DATA_W  payload word
//   bit_en     in   1       bit strobe; the frame advances only when high
//   sout       out  1       serial data, registered
//   sof        out  1       high with the first payload bit
//   sout_vld   out  1       high while sout carries a frame bit
//   busy       out  1       high from the start edge until done
//   done       out  1       1-cycle pulse after the last CRC bit is retired
//   crc        out  16      CRC of the last frame, valid from done to next start
//   dbg_state  out  2       current sequencer state, for observation only
//
// Handshake: start is a request sampled only in IDLE (ignored while busy,
// including the FIN cycle); there is no backpressure from the receiver.
// bit_en is a pacing strobe: each bit is presented for the cycle after an
// enabled edge with sout_vld=1, and on cycles after a disabled edge sout
// holds its value while sout_vld and sof are low.
module crc16_serial_tx
    import crc16_serial_tx_pkg::*;
#(
    parameter int          DATA_W = 32,
    parameter logic [15:0] POLY   = CRC16_POLY,
    parameter logic [15:0] INIT   = CRC16_INIT
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [DATA_W-1:0] din,
    input  logic              bit_en,
    output logic              sout,
    output logic              sof,
    output logic              sout_vld,
    output logic              busy,
    output logic              done,
    output logic [15:0]       crc,
    output state_t            dbg_state
);

    // One extra bit so the count never wraps inside a frame.
    localparam int CNT_W = $clog2(DATA_W) + 1;

    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] LAST_CRC  = CNT_W'(15);

    state_t            state;
    logic [DATA_W-1:0] shreg;
    logic [15:0]       crc_r;
    logic [15:0]       crc_save;
    logic [15:0]       crc_step;
    logic [CNT_W-1:0]  cnt;

    crc16_serial_tx_step #(
        .POLY (POLY)
    ) u_step (
        .crc_in   (crc_r),
        .data_bit (shreg[DATA_W-1]),
        .crc_out  (crc_step)
    );

    assign dbg_state = state;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            shreg    <= '0;
            crc_r    <= INIT;
            crc_save <= 16'h0000;
            cnt      <= '0;
            sout     <= 1'b0;
            sof      <= 1'b0;
            sout_vld <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            crc      <= 16'h0000;
        end else begin
            case (state)
                S_IDLE: begin
                    sof      <= 1'b0;
                    sout_vld <= 1'b0;
                    done     <= 1'b0;
                    if (start) begin
                        shreg <= din;
                        crc_r <= INIT;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= S_DATA;
                    end
                end

                S_DATA: begin
                    done <= 1'b0;
                    if (bit_en) begin
                        sout     <= shreg[DATA_W-1];
                        sout_vld <= 1'b1;
                        sof      <= (cnt == '0);
                        shreg    <= {shreg[DATA_W-2:0], 1'b0};
                        crc_r    <= crc_step;
                        if (cnt == LAST_DATA) begin
                            // crc_r is consumed by shifting during the CRC
                            // phase, so the finished value is kept aside.
                            crc_save <= crc_step;
                            cnt      <= '0;
                            state    <= S_CRC;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else begin
                        sout_vld <= 1'b0;
                        sof      <= 1'b0;
                    end
                end

                S_CRC: begin
                    sof  <= 1'b0;
                    done <= 1'b0;
                    if (bit_en) begin
                        sout     <= crc_r[15];
                        sout_vld <= 1'b1;
                        crc_r    <= {crc_r[14:0], 1'b0};
                        if (cnt == LAST_CRC) begin
                            state <= S_FIN;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else begin
                        sout_vld <= 1'b0;
                    end
                end

                S_FIN: begin
                    // Not paced by bit_en: completion is reported on the
                    // first clock after the last CRC bit was presented.
                    sof      <= 1'b0;
                    sout_vld <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    crc      <= crc_save;
                    state    <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crc16_serial_tx.sv
// Self-checking bench for crc16_serial_tx (DATA_W=32, POLY=16'h8005, INIT=0).
// The reference CRC is computed by polynomial long division of din*x^16 by
// x^16+POLY; the expected frame is a queue of bits consumed by one monitor.
module tb_crc16_serial_tx;
    import crc16_serial_tx_pkg::*;

    localparam int DATA_W = 32;
    localparam int FRAME  = DATA_W + 16;

    // ---------------- clock / reset ----------------
    logic              clock   = 1'b0;
    logic              reset_n = 1'b0;
    logic              start   = 1'b0;
    logic              bit_en  = 1'b0;
    logic [DATA_W-1:0] din     = '0;
    logic              sout, sof, sout_vld, busy, done;
    logic [15:0]       crc;
    state_t            dbg_state;

    always #5 clock = ~clock;

    crc16_serial_tx #(
        .DATA_W (DATA_W)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .din       (din),
        .bit_en    (bit_en),
        .sout      (sout),
        .sof       (sof),
        .sout_vld  (sout_vld),
        .busy      (busy),
        .done      (done),
        .crc       (crc),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int          n_cmp  = 0;
    int          n_fail = 0;
    logic        exp_q[$];
    logic [15:0] exp_crc = 16'h0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Remainder of d(x)*x^16 modulo x^16+POLY(x), by long division.
    function automatic logic [15:0] model_crc(input logic [DATA_W-1:0] d);
        logic [DATA_W+15:0] r;
        r = {d, 16'h0000};
        for (int i = DATA_W + 15; i >= 16; i--) begin
            if (r[i]) r[i -: 17] = r[i -: 17] ^ {1'b1, CRC16_POLY};
        end
        return r[15:0];
    endfunction

    task automatic load_expect(input logic [DATA_W-1:0] d);
        exp_q.delete();
        exp_crc = model_crc(d);
        for (int i = DATA_W - 1; i >= 0; i--) exp_q.push_back(d[i]);
        for (int i = 15; i >= 0; i--) exp_q.push_back(exp_crc[i]);
    endtask

    // Single compare process: every cycle with a frame bit on the wire, and
    // every done pulse, is checked against the queue.
    always @(negedge clock) begin
        if (reset_n) begin
            if (sout_vld) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL extra_bit: got sout=%0b with no bit expected (t=%0t)", sout, $time);
                end else begin
                    check("sof", 64'(sof), 64'(exp_q.size() == FRAME));
                    check("sout_bit", 64'(sout), 64'(exp_q.pop_front()));
                end
            end else if (sof) begin
                check("sof_idle", 64'(sof), 64'(0));
            end
            if (done) begin
                check("done_crc", 64'(crc), 64'(exp_crc));
                check("bits_left", 64'(exp_q.size()), 64'(0));
            end
        end
    end

    // ---------------- driver ----------------
    // Runs one frame. done_edge = clock edges from the start edge to the edge
    // that raises done (-1 if it never came). restart_at>0 pulses a second
    // start with a different word after that edge.
    task automatic run_frame(input logic [DATA_W-1:0] d, input bit toggle,
                             input int restart_at, output int done_edge);
        int stall_bad;
        load_expect(d);
        @(negedge clock);
        din    = d;
        start  = 1'b1;
        bit_en = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        din   = $urandom;
        check("busy_after_start", 64'(busy), 64'(1));
        done_edge = -1;
        stall_bad = 0;
        for (int e = 1; e <= 300; e++) begin
            @(posedge clock);
            #1;
            if (done) begin
                done_edge = e;
                break;
            end
            if (toggle && (e % 2 == 0) && sout_vld) stall_bad++;
            bit_en = toggle ? (e % 2 == 0) : 1'b1;
            if (e == restart_at) begin
                start = 1'b1;
                din   = 32'hFFFF_FFFF;
            end else begin
                start = 1'b0;
            end
        end
        start  = 1'b0;
        bit_en = 1'b1;
        if (toggle) check("stall_vld_low", 64'(stall_bad), 64'(0));
        if (done_edge < 0) begin
            $display("FAIL done_timeout: got no done expected done within 300 clocks");
            n_cmp++;
            n_fail++;
        end else begin
            check("busy_at_done", 64'(busy), 64'(0));
        end
        // crc must hold and done must be a single pulse.
        repeat (3) @(posedge clock);
        #1;
        check("crc_hold", 64'(crc), 64'(exp_crc));
        check("done_pulse", 64'(done), 64'(0));
    endtask

    int de;

    initial begin
        // Reset state
        #1;
        check("rst_sout", 64'(sout), 64'(0));
        check("rst_vld", 64'(sout_vld), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_crc", 64'(crc), 64'(0));
        check("rst_state", 64'(dbg_state), 64'(S_IDLE));
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // Pin the model to hand-derived values
        check("model_crc_1", 64'(model_crc(32'h0000_0001)), 64'h8005);
        check("model_crc_2", 64'(model_crc(32'h0000_0002)), 64'h800F);

        // 1: din=1, full rate. done is raised by the 49th edge after the
        // start edge, i.e. it is high in the 50th clock counting the start cycle.
        run_frame(32'h0000_0001, 1'b0, 0, de);
        check("t1_latency", 64'(de), 64'(FRAME + 1));
        check("t1_crc", 64'(crc), 64'h8005);

        // 2: din=2
        run_frame(32'h0000_0002, 1'b0, 0, de);
        check("t2_latency", 64'(de), 64'(FRAME + 1));
        check("t2_crc", 64'(crc), 64'h800F);

        // 3: mixed payload, checked against the model bit by bit
        run_frame(32'h0301_0203, 1'b0, 0, de);
        check("t3_latency", 64'(de), 64'(FRAME + 1));

        // 4: bit_en 1,0,1,0 -> 48 enabled edges spread over 95, FIN on the 96th
        run_frame(32'h0000_0001, 1'b1, 0, de);
        check("t4_latency", 64'(de), 64'(2 * FRAME));
        check("t4_crc", 64'(crc), 64'h8005);

        // 5: second start at bit 10 is ignored
        run_frame(32'h0000_0001, 1'b0, 10, de);
        check("t5_latency", 64'(de), 64'(FRAME + 1));
        check("t5_crc", 64'(crc), 64'h8005);

        // 6: reset low at bit 20 aborts the frame asynchronously
        load_expect(32'h0000_0001);
        @(negedge clock);
        din   = 32'h0000_0001;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (20) @(posedge clock);
        #1;
        check("t6_mid_vld", 64'(sout_vld), 64'(1));
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_sout", 64'(sout), 64'(0));
        check("t6_vld", 64'(sout_vld), 64'(0));
        check("t6_sof", 64'(sof), 64'(0));
        check("t6_busy", 64'(busy), 64'(0));
        check("t6_done", 64'(done), 64'(0));
        check("t6_crc", 64'(crc), 64'(0));
        check("t6_state", 64'(dbg_state), 64'(S_IDLE));
        exp_q.delete();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        check("t6_no_done", 64'(done), 64'(0));
        check("t6_idle_busy", 64'(busy), 64'(0));
        run_frame(32'h0000_0001, 1'b0, 0, de);
        check("t6_latency", 64'(de), 64'(FRAME + 1));
        check("t6_crc_after", 64'(crc), 64'h8005);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
